// File: rtl/register_file_param.sv
// ============================================================================
// Module      : register_file_param
// Description : Parametrised 2-read/1-write register file with registered
//               read ports, write-to-read bypass, optional zero register and
//               a sequential bulk-clear engine (req/busy/done).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_en,
    input  logic [ADDR_W-1:0] reg_write_dest,
    input  logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    output logic [DATA_W-1:0] reg_read_data_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    output logic [DATA_W-1:0] reg_read_data_2,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              wr_accept;

    // A clear request in IDLE wins over a coincident write; writes reopen in DONE.
    assign wr_accept = reg_write_en
                     && ((state_q == S_DONE) || ((state_q == S_IDLE) && !clear_req))
                     && !(ZERO_REG && (reg_write_dest == '0));

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end
            end
            S_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd1_d = mem_q[reg_read_addr_1];
        if (ZERO_REG && (reg_read_addr_1 == '0)) begin
            rd1_d = '0;
        end else if (BYPASS && wr_accept && (reg_write_dest == reg_read_addr_1)) begin
            rd1_d = reg_write_data;
        end
    end

    always_comb begin
        rd2_d = mem_q[reg_read_addr_2];
        if (ZERO_REG && (reg_read_addr_2 == '0)) begin
            rd2_d = '0;
        end else if (BYPASS && wr_accept && (reg_write_dest == reg_read_addr_2)) begin
            rd2_d = reg_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clr_idx_q <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            if (state_q == S_CLEAR) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_accept) begin
                mem_q[reg_write_dest] <= reg_write_data;
            end
        end
    end

    assign reg_read_data_1 = rd1_q;
    assign reg_read_data_2 = rd2_q;
    assign clear_busy      = (state_q == S_CLEAR);
    assign clear_done      = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_register_file_param.sv
// ============================================================================
// Module      : tb_register_file_param
// Description : Directed vector bench for register_file_param (default build
//               plus a BYPASS=0 / ZERO_REG=0 build sharing the write/read bus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  dest;
    logic [15:0] wd;
    logic [3:0]  ra1, ra2;
    logic [15:0] rd1, rd2;
    logic        busy, done;
    logic        clr;
    logic [15:0] nb_rd1, nb_rd2;
    logic        nb_busy, nb_done;
    logic        nb_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    register_file_param u_dut (
        .clk             (clk),
        .rst             (rst),
        .reg_write_en    (we),
        .reg_write_dest  (dest),
        .reg_write_data  (wd),
        .reg_read_addr_1 (ra1),
        .reg_read_data_1 (rd1),
        .reg_read_addr_2 (ra2),
        .reg_read_data_2 (rd2),
        .clear_req       (clr),
        .clear_busy      (busy),
        .clear_done      (done)
    );

    register_file_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
        .clk             (clk),
        .rst             (rst),
        .reg_write_en    (we),
        .reg_write_dest  (dest),
        .reg_write_data  (wd),
        .reg_read_addr_1 (ra1),
        .reg_read_data_1 (nb_rd1),
        .reg_read_addr_2 (ra2),
        .reg_read_data_2 (nb_rd2),
        .clear_req       (nb_clr),
        .clear_busy      (nb_busy),
        .clear_done      (nb_done)
    );

    typedef struct {
        logic        we;
        logic [3:0]  dest;
        logic [15:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] nb2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_sweep(input string name);
        we = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ra1 = 4'(a);
            ra2 = 4'(15 - a);
            step();
            chk(name, rd1, 16'h0000);
            chk(name, rd2, 16'h0000);
        end
    endtask

    // Runs one clear from a request in IDLE, counting busy cycles and done pulses.
    task automatic run_clear(input string name);
        int busy_cnt;
        int done_cnt;
        clr = 1'b1;
        step();
        clr = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step();
            busy_cnt += busy ? 1 : 0;
            done_cnt += done ? 1 : 0;
        end
        chk({name, "_busy_cycles"}, 16'(busy_cnt), 16'd16);
        chk({name, "_done_pulses"}, 16'(done_cnt), 16'd1);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_k;
        bit got_done;

        vecs[0] = '{1'b1, 4'd5, 16'hBEEF, 4'd1, 4'd2, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[2] = '{1'b1, 4'd0, 16'h1234, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h1234};
        vecs[4] = '{1'b1, 4'd7, 16'hA5A5, 4'd5, 4'd7, 16'hBEEF, 16'hA5A5, 16'h0000};
        vecs[5] = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 16'hA5A5, 16'hA5A5, 16'hA5A5};
        vecs[6] = '{1'b1, 4'd5, 16'h0102, 4'd5, 4'd7, 16'h0102, 16'hA5A5, 16'hA5A5};
        vecs[7] = '{1'b1, 4'd3, 16'h3333, 4'd3, 4'd5, 16'h3333, 16'h0102, 16'h0102};
        vecs[8] = '{1'b0, 4'd0, 16'h0000, 4'd3, 4'd3, 16'h3333, 16'h3333, 16'h3333};

        rst = 1'b0; we = 1'b0; dest = '0; wd = '0; ra1 = '0; ra2 = '0;
        clr = 1'b0; nb_clr = 1'b0;
        step();
        step();
        chk("reset_rd1", rd1, 16'h0000);
        chk("reset_rd2", rd2, 16'h0000);
        chk("reset_busy", 16'(busy), 16'h0000);
        chk("reset_done", 16'(done), 16'h0000);
        rst = 1'b1;
        zero_sweep("reset_sweep");

        // Write/readback, zero register and bypass vectors.
        for (int i = 0; i < 9; i++) begin
            we = vecs[i].we; dest = vecs[i].dest; wd = vecs[i].wd;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            step();
            chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e2);
            chk($sformatf("vec%0d_nb_rd2", i), nb_rd2, vecs[i].nb2);
        end

        // Fill, then clear with a dropped write and an ignored request mid-clear.
        for (int i = 1; i < 16; i++) begin
            we = 1'b1; dest = 4'(i); wd = 16'h00FF + 16'(i);
            step();
        end
        we = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        done_k = -1;
        for (int k = 1; k < 25; k++) begin
            we = 1'b0; clr = 1'b0;
            if (k == 2) ra1 = 4'd15;
            if (k == 8) begin
                we = 1'b1; dest = 4'd3; wd = 16'h1111; clr = 1'b1;
            end
            step();
            if (k == 2) chk("clear_partial_rd1", rd1, 16'h010E);
            busy_cnt += busy ? 1 : 0;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
        end
        we = 1'b0; clr = 1'b0;
        chk("clear_busy_cycles", 16'(busy_cnt), 16'd16);
        chk("clear_done_pulses", 16'(done_cnt), 16'd1);
        chk("clear_done_cycle", 16'(done_k), 16'd16);
        zero_sweep("post_clear_sweep");

        // Reset during the sixth CLEAR cycle.
        we = 1'b1; dest = 4'd12; wd = 16'hC0DE;
        step();
        we = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midclr_busy_before", 16'(busy), 16'h0001);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midclr_busy_after", 16'(busy), 16'h0000);
        chk("midclr_done_after", 16'(done), 16'h0000);
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            done_cnt += done ? 1 : 0;
        end
        chk("midclr_no_done", 16'(done_cnt), 16'd0);
        zero_sweep("midclr_sweep");
        run_clear("reclear");

        // Clear request and write together in IDLE: write dropped, not bypassed.
        we = 1'b1; dest = 4'd9; wd = 16'h9999;
        step();
        we = 1'b1; dest = 4'd9; wd = 16'hCAFE; clr = 1'b1; ra2 = 4'd9;
        step();
        we = 1'b0; clr = 1'b0;
        chk("simul_no_bypass", rd2, 16'h9999);
        got_done = 1'b0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            step();
            if (done) got_done = 1'b1;
        end
        chk("simul_done_seen", 16'(got_done), 16'h0001);
        // A write in the DONE cycle is accepted.
        we = 1'b1; dest = 4'd2; wd = 16'h2222; ra1 = 4'd9; ra2 = 4'd2;
        step();
        we = 1'b0;
        chk("simul_rd_reg9", rd1, 16'h0000);
        chk("done_write_bypass", rd2, 16'h2222);
        ra1 = 4'd2;
        step();
        chk("done_write_readback", rd1, 16'h2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
